// File: rtl/probe_counter_bank_if.sv
// Snapshot handshake bundle for probe_counter_bank.
//   snap_req    requester -> bank   ask for an atomic copy of all counters
//   snap_valid  bank -> requester   captured copy is being held
//   snap_ready  requester -> bank   requester accepts the held copy
//   snap_data   bank -> requester   captured counts, channel i at [i*WIDTH +: WIDTH]
//   snap_flags  bank -> requester   captured wrap flags
//   snap_miss   bank -> requester   request arrived while a copy was still held
// The master modport is the counter bank; the slave modport is the consumer.
interface probe_counter_bank_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
);
  logic                    snap_req;
  logic                    snap_valid;
  logic                    snap_ready;
  logic [NUM_CH*WIDTH-1:0] snap_data;
  logic [NUM_CH-1:0]       snap_flags;
  logic                    snap_miss;

  modport master (
    input  snap_req,
    input  snap_ready,
    output snap_valid,
    output snap_data,
    output snap_flags,
    output snap_miss
  );

  modport slave (
    output snap_req,
    output snap_ready,
    input  snap_valid,
    input  snap_data,
    input  snap_flags,
    input  snap_miss
  );
endinterface

// File: rtl/probe_counter_bank.sv
// Bank of NUM_CH independent up/down counters with a live probe bus and an
// atomic snapshot port.
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   en_i           per-channel count enable
//   dir_i          per-channel direction, 1 = up, 0 = down
//   clr_i          per-channel synchronous clear (highest priority)
//   ld_i           per-channel synchronous load
//   ld_val_i       load values, channel i at [i*WIDTH +: WIDTH]
//   probe_cnt_o    live counter registers, same packing as ld_val_i
//   probe_msb_o    MSB of each live counter
//   wrap_flag_o    sticky wrap / saturation-hit flag per channel
//   snap           snapshot handshake (master side)
// SATURATE = 0 wraps modulo 2^WIDTH, SATURATE = 1 clamps at 0 / all-ones.
module probe_counter_bank #(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH-1:0]       dir_i,
  input  logic [NUM_CH-1:0]       clr_i,
  input  logic [NUM_CH-1:0]       ld_i,
  input  logic [NUM_CH*WIDTH-1:0] ld_val_i,
  output logic [NUM_CH*WIDTH-1:0] probe_cnt_o,
  output logic [NUM_CH-1:0]       probe_msb_o,
  output logic [NUM_CH-1:0]       wrap_flag_o,
  probe_counter_bank_if.master    snap
);

  typedef enum logic {IDLE, HOLD} snapState_e;

  snapState_e              state_q, state_d;
  logic [WIDTH-1:0]        cnt_q [NUM_CH];
  logic [WIDTH-1:0]        cnt_d [NUM_CH];
  logic [NUM_CH-1:0]       wrapFlag_q, wrapFlag_d;
  logic [NUM_CH-1:0]       wrapEv;
  logic [NUM_CH*WIDTH-1:0] snapData_q, snapData_d;
  logic [NUM_CH-1:0]       snapFlags_q, snapFlags_d;
  logic                    capture;
  logic                    accept;

  assign capture = (state_q == IDLE) && snap.snap_req;
  assign accept  = (state_q == HOLD) && snap.snap_ready;

  // Counter next-state and flag update. A wrap event is detected on the
  // pre-update value whenever the enable wins priority, in both modes; in
  // saturating mode the same event simply holds the count instead of rolling.
  // The flag ordering is clr, then a new wrap event, then snapshot acceptance,
  // so a wrap coinciding with acceptance survives the accept-clear.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]      = cnt_q[i];
      wrapEv[i]     = 1'b0;
      wrapFlag_d[i] = wrapFlag_q[i];
      if (clr_i[i]) begin
        cnt_d[i] = '0;
      end else if (ld_i[i]) begin
        cnt_d[i] = ld_val_i[i*WIDTH +: WIDTH];
      end else if (en_i[i]) begin
        if (dir_i[i]) begin
          wrapEv[i] = &cnt_q[i];
          if (!(wrapEv[i] && SATURATE)) cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end else begin
          wrapEv[i] = (cnt_q[i] == '0);
          if (!(wrapEv[i] && SATURATE)) cnt_d[i] = cnt_q[i] - WIDTH'(1);
        end
      end
      if (clr_i[i])       wrapFlag_d[i] = 1'b0;
      else if (wrapEv[i]) wrapFlag_d[i] = 1'b1;
      else if (accept)    wrapFlag_d[i] = 1'b0;
    end
  end

  // The snapshot copies the registered counts, i.e. the values before the
  // update made on the same edge.
  always_comb begin
    snapData_d  = snapData_q;
    snapFlags_d = snapFlags_q;
    if (capture) begin
      snapData_d  = probe_cnt_o;
      snapFlags_d = wrapFlag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      wrapFlag_q  <= '0;
      snapData_q  <= '0;
      snapFlags_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      wrapFlag_q  <= wrapFlag_d;
      snapData_q  <= snapData_d;
      snapFlags_q <= snapFlags_d;
    end
  end

  // Snapshot FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Snapshot FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (snap.snap_req)   state_d = HOLD;
      HOLD:    if (snap.snap_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Snapshot FSM outputs. Valid is decoded from state so an asynchronous
  // reset drops it immediately; a request seen while holding is a miss,
  // including one in the acceptance cycle.
  always_comb begin
    snap.snap_valid = (state_q == HOLD);
    snap.snap_miss  = (state_q == HOLD) && snap.snap_req;
    snap.snap_data  = snapData_q;
    snap.snap_flags = snapFlags_q;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gProbe
    assign probe_cnt_o[g*WIDTH +: WIDTH] = cnt_q[g];
    assign probe_msb_o[g]                = cnt_q[g][WIDTH-1];
  end

  assign wrap_flag_o = wrapFlag_q;

endmodule

// File: tb/tb_probe_counter_bank.sv
// Directed testbench for probe_counter_bank. Instance A wraps (SATURATE=0),
// instance B saturates (SATURATE=1); both share the counter control inputs,
// only A's snapshot port is exercised.
module tb_probe_counter_bank;

  logic        clk;
  logic        rst_n;
  logic [3:0]  en, dir, clr, ld;
  logic [31:0] ldVal;
  logic [31:0] probeA, probeB;
  logic [3:0]  msbA, msbB, wrapA, wrapB;
  int          checks;
  int          errors;

  probe_counter_bank_if #(.NUM_CH(4), .WIDTH(8)) ifA ();
  probe_counter_bank_if #(.NUM_CH(4), .WIDTH(8)) ifB ();

  probe_counter_bank #(.NUM_CH(4), .WIDTH(8), .SATURATE(1'b0)) dutA (
    .clk(clk), .rst_n(rst_n), .en_i(en), .dir_i(dir), .clr_i(clr), .ld_i(ld),
    .ld_val_i(ldVal), .probe_cnt_o(probeA), .probe_msb_o(msbA),
    .wrap_flag_o(wrapA), .snap(ifA)
  );

  probe_counter_bank #(.NUM_CH(4), .WIDTH(8), .SATURATE(1'b1)) dutB (
    .clk(clk), .rst_n(rst_n), .en_i(en), .dir_i(dir), .clr_i(clr), .ld_i(ld),
    .ld_val_i(ldVal), .probe_cnt_o(probeB), .probe_msb_o(msbB),
    .wrap_flag_o(wrapB), .snap(ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] chA(input int i);
    return probeA[i*8 +: 8];
  endfunction

  function automatic logic [7:0] chB(input int i);
    return probeB[i*8 +: 8];
  endfunction

  // Drive one cycle of counter controls, then sample 1ns after the edge.
  task automatic applyStimulus(input logic [3:0] e, input logic [3:0] d,
                               input logic [3:0] c, input logic [3:0] l,
                               input logic [31:0] lv);
    en = e; dir = d; clr = c; ld = l; ldVal = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en = '0; dir = '0; clr = '0; ld = '0; ldVal = '0;
    ifA.snap_req = 1'b0; ifA.snap_ready = 1'b0;
    ifB.snap_req = 1'b0; ifB.snap_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    checkOutput("rst_probe", probeA, 32'h0);
    checkOutput("rst_wrap", {28'h0, wrapA}, 32'h0);
    checkOutput("rst_valid", {31'h0, ifA.snap_valid}, 32'h0);
    checkOutput("rst_miss", {31'h0, ifA.snap_miss}, 32'h0);
    checkOutput("rst_sdata", ifA.snap_data, 32'h0);

    // Wrap on ch0: FE -> FF -> 00 -> 01
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0001, 32'h0000_00FE);
    checkOutput("t2_ld", {24'h0, chA(0)}, 32'hFE);
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 4'b0000, 32'h0);
    checkOutput("t2_c1", {24'h0, chA(0)}, 32'hFF);
    checkOutput("t2_msb1", {31'h0, msbA[0]}, 32'h1);
    checkOutput("t2_flag1", {31'h0, wrapA[0]}, 32'h0);
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 4'b0000, 32'h0);
    checkOutput("t2_c2", {24'h0, chA(0)}, 32'h00);
    checkOutput("t2_msb2", {31'h0, msbA[0]}, 32'h0);
    checkOutput("t2_flag2", {31'h0, wrapA[0]}, 32'h1);
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 4'b0000, 32'h0);
    checkOutput("t2_c3", {24'h0, chA(0)}, 32'h01);
    checkOutput("t2_msb3", {31'h0, msbA[0]}, 32'h0);

    // Priority on ch2: clr beats ld and en, ld beats en
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0100, 32'h0037_0000);
    checkOutput("t4_ld37", {24'h0, chA(2)}, 32'h37);
    applyStimulus(4'b0100, 4'b0100, 4'b0100, 4'b0100, 32'h00AA_0000);
    checkOutput("t4_clr", {24'h0, chA(2)}, 32'h00);
    applyStimulus(4'b0100, 4'b0100, 4'b0000, 4'b0100, 32'h00AA_0000);
    checkOutput("t4_ld", {24'h0, chA(2)}, 32'hAA);

    // Down-count on ch1 from 01: B clamps at 0, A rolls to FF
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0010, 32'h0000_0100);
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 4'b0000, 32'h0);
    checkOutput("t3_b1", {24'h0, chB(1)}, 32'h00);
    checkOutput("t3_bflag1", {31'h0, wrapB[1]}, 32'h0);
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 4'b0000, 32'h0);
    checkOutput("t3_b2", {24'h0, chB(1)}, 32'h00);
    checkOutput("t3_bflag2", {31'h0, wrapB[1]}, 32'h1);
    checkOutput("t3_a2", {24'h0, chA(1)}, 32'hFF);
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 4'b0000, 32'h0);
    checkOutput("t3_b3", {24'h0, chB(1)}, 32'h00);
    checkOutput("t3_a3", {24'h0, chA(1)}, 32'hFE);

    // Snapshot held while ch0 keeps counting
    applyStimulus(4'b0000, 4'b0000, 4'b1111, 4'b0000, 32'h0);
    checkOutput("t5_clrflags", {28'h0, wrapA}, 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0001, 32'h0000_0010);
    ifA.snap_req = 1'b1;
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 4'b0000, 32'h0);
    ifA.snap_req = 1'b0;
    checkOutput("t5_valid", {31'h0, ifA.snap_valid}, 32'h1);
    checkOutput("t5_cap", {24'h0, ifA.snap_data[7:0]}, 32'h10);
    checkOutput("t5_live", {24'h0, chA(0)}, 32'h11);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        ifA.snap_req = 1'b1;
        #1;
        checkOutput("t5_miss", {31'h0, ifA.snap_miss}, 32'h1);
      end
      if (k == 0) applyStimulus(4'b0011, 4'b0001, 4'b0000, 4'b0000, 32'h0);
      else        applyStimulus(4'b0001, 4'b0001, 4'b0000, 4'b0000, 32'h0);
      ifA.snap_req = 1'b0;
      #1;
      checkOutput("t5_hold_data", ifA.snap_data, 32'h0000_0010);
      checkOutput("t5_hold_valid", {31'h0, ifA.snap_valid}, 32'h1);
      checkOutput("t5_hold_live", {24'h0, chA(0)}, 32'h12 + k);
      checkOutput("t5_hold_miss", {31'h0, ifA.snap_miss}, 32'h0);
    end
    checkOutput("t5_flag1", {31'h0, wrapA[1]}, 32'h1);
    checkOutput("t5_sflags", {28'h0, ifA.snap_flags}, 32'h0);
    ifA.snap_ready = 1'b1;
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 4'b0000, 32'h0);
    ifA.snap_ready = 1'b0;
    checkOutput("t5_acc_valid", {31'h0, ifA.snap_valid}, 32'h0);
    checkOutput("t5_acc_flags", {28'h0, wrapA}, 32'h0);
    checkOutput("t5_acc_live", {24'h0, chA(0)}, 32'h17);

    // Wrap on ch3 in the acceptance cycle
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b1000, 32'hFF00_0000);
    ifA.snap_req = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0);
    ifA.snap_req = 1'b0;
    checkOutput("t6_valid", {31'h0, ifA.snap_valid}, 32'h1);
    ifA.snap_ready = 1'b1;
    applyStimulus(4'b1000, 4'b1000, 4'b0000, 4'b0000, 32'h0);
    ifA.snap_ready = 1'b0;
    checkOutput("t6_acc_valid", {31'h0, ifA.snap_valid}, 32'h0);
    checkOutput("t6_sflag3", {31'h0, ifA.snap_flags[3]}, 32'h0);
    checkOutput("t6_sdata3", {24'h0, ifA.snap_data[31:24]}, 32'hFF);
    checkOutput("t6_flag3", {31'h0, wrapA[3]}, 32'h1);
    checkOutput("t6_c3", {24'h0, chA(3)}, 32'h00);

    // Asynchronous reset in the middle of a held snapshot
    ifA.snap_req = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0);
    ifA.snap_req = 1'b0;
    checkOutput("t1_pre_valid", {31'h0, ifA.snap_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("t1_valid", {31'h0, ifA.snap_valid}, 32'h0);
    checkOutput("t1_probe", probeA, 32'h0);
    checkOutput("t1_wrap", {28'h0, wrapA}, 32'h0);
    checkOutput("t1_sdata", ifA.snap_data, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0);
    checkOutput("t1_idle_valid", {31'h0, ifA.snap_valid}, 32'h0);
    ifA.snap_req = 1'b1;
    #1;
    checkOutput("t1_idle_miss", {31'h0, ifA.snap_miss}, 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0);
    ifA.snap_req = 1'b0;
    checkOutput("t1_recap_valid", {31'h0, ifA.snap_valid}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
